// File: rtl/ethsim_pkg.sv
// Shared types and helpers for the Ethernet TX sink emulator.
package ethsim_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_GAP,
      ST_STOP
   } state_e;

   function automatic int gap_cycles(int npre, int nifg);
      int g;
      g = (npre + nifg + 7) / 8;
      return (g < 1) ? 1 : g;
   endfunction

   function automatic logic keep_legal(logic [7:0] k);
      return (k != 8'h00) && ((k & (k + 8'd1)) == 8'h00);
   endfunction

   function automatic logic [3:0] popcount8(logic [7:0] k);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'b000, k[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_keep_decode.sv
// Maps a tkeep mask to its byte count and contiguity flag.
module eth_keep_decode
   import ethsim_pkg::*;
(
   input  logic [7:0] keep_i,
   output logic [3:0] count_o,
   output logic       legal_o
);

   assign count_o = popcount8(keep_i);
   assign legal_o = keep_legal(keep_i);

endmodule

// File: rtl/eth_tx_sink.sv
// AXI-Stream frame sink emulating line-rate pacing and frame checks.
module eth_tx_sink
   import ethsim_pkg::*;
#(
   parameter int max_recvpkt = 10,
   parameter int nPreamble   = 8,
   parameter int nIFG        = 12,
   parameter int min_len     = 60,
   parameter int max_len     = 1518
) (
   input  logic        clk156,
   input  logic        cold_reset_n,
   output logic        s_axis_tready,
   input  logic        s_axis_tvalid,
   input  logic [63:0] s_axis_tdata,
   input  logic [7:0]  s_axis_tkeep,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tuser,
   output logic        pkt_done,
   output logic [15:0] pkt_len,
   output logic [15:0] pkt_cnt,
   output logic        err_user,
   output logic        err_keep,
   output logic        err_runt,
   output logic        err_oversize,
   output logic        done
);

   localparam int          G      = gap_cycles(nPreamble, nIFG);
   localparam logic [7:0]  GAP_LD = 8'(G - 1);
   localparam logic [15:0] MAXCNT = 16'(max_recvpkt);
   localparam logic [15:0] MINLEN = 16'(min_len);
   localparam logic [15:0] MAXLEN = 16'(max_len);

   state_e      state_q;
   logic        tready_q;
   logic        done_q;
   logic        pkt_done_q;
   logic [15:0] pkt_len_q;
   logic [15:0] pkt_cnt_q;
   logic [15:0] acc_len_q;
   logic [7:0]  gap_q;
   logic        err_user_q;
   logic        err_keep_q;
   logic        err_runt_q;
   logic        err_oversize_q;

   logic [3:0]  keep_cnt;
   logic        keep_ok;
   logic        accept;
   logic [16:0] sum;
   logic [15:0] len_d;
   logic [15:0] cnt_d;
   logic        bad_keep_d;
   logic        unused_data;

   eth_keep_decode u_keep (
      .keep_i  (s_axis_tkeep),
      .count_o (keep_cnt),
      .legal_o (keep_ok)
   );

   assign unused_data = ^s_axis_tdata;
   assign accept      = s_axis_tvalid & tready_q;

   // Saturating byte accumulator: full beats add 8, the last adds its keep count.
   assign sum   = {1'b0, acc_len_q}
                + (s_axis_tlast ? {13'd0, keep_cnt} : 17'd8);
   assign len_d = sum[16] ? 16'hFFFF : sum[15:0];
   assign cnt_d = pkt_cnt_q + 16'd1;

   assign bad_keep_d = s_axis_tlast ? !keep_ok
                                    : (s_axis_tkeep != 8'hFF);

   always_ff @(posedge clk156 or negedge cold_reset_n) begin
      if (!cold_reset_n) begin
         state_q        <= ST_IDLE;
         tready_q       <= 1'b0;
         done_q         <= 1'b0;
         pkt_done_q     <= 1'b0;
         pkt_len_q      <= '0;
         pkt_cnt_q      <= '0;
         acc_len_q      <= '0;
         gap_q          <= '0;
         err_user_q     <= 1'b0;
         err_keep_q     <= 1'b0;
         err_runt_q     <= 1'b0;
         err_oversize_q <= 1'b0;
      end else begin
         pkt_done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE, ST_RECV: begin
               tready_q <= 1'b1;
               if (accept) begin
                  err_user_q <= err_user_q | s_axis_tuser;
                  err_keep_q <= err_keep_q | bad_keep_d;
                  if (s_axis_tlast) begin
                     pkt_done_q <= 1'b1;
                     pkt_len_q  <= len_d;
                     pkt_cnt_q  <= cnt_d;
                     acc_len_q  <= '0;
                     tready_q   <= 1'b0;
                     if (len_d < MINLEN) err_runt_q <= 1'b1;
                     if (len_d > MAXLEN) err_oversize_q <= 1'b1;
                     if (cnt_d == MAXCNT) begin
                        state_q <= ST_STOP;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= ST_GAP;
                        gap_q   <= GAP_LD;
                     end
                  end else begin
                     acc_len_q <= len_d;
                     state_q   <= ST_RECV;
                  end
               end
            end
            ST_GAP: begin
               if (gap_q == 8'd0) begin
                  state_q  <= ST_IDLE;
                  tready_q <= 1'b1;
               end else begin
                  gap_q <= gap_q - 8'd1;
               end
            end
            ST_STOP: begin
               tready_q <= 1'b0;
               done_q   <= 1'b1;
            end
         endcase
      end
   end

   assign s_axis_tready = tready_q;
   assign pkt_done      = pkt_done_q;
   assign pkt_len       = pkt_len_q;
   assign pkt_cnt       = pkt_cnt_q;
   assign err_user      = err_user_q;
   assign err_keep      = err_keep_q;
   assign err_runt      = err_runt_q;
   assign err_oversize  = err_oversize_q;
   assign done          = done_q;

endmodule
